// File: rtl/alu_op_pkg.sv
// Shared alu_op encodings for the decoder and execute units, plus small divide-op helpers.
// Pure declarations: no latency, no flow control.
package alu_op_pkg;

  typedef logic [4:0] alu_op_t;

  localparam alu_op_t DIVU_OP = 5'b01101;
  localparam alu_op_t DIVS_OP = 5'b01110;
  localparam alu_op_t REMU_OP = 5'b01111;
  localparam alu_op_t REMS_OP = 5'b10000;

  // Unknown opcodes fall out of both helpers as 0, so they behave as DIVU.
  function automatic logic op_is_signed(input alu_op_t op);
    return (op == DIVS_OP) || (op == REMS_OP);
  endfunction

  function automatic logic op_is_rem(input alu_op_t op);
    return (op == REMU_OP) || (op == REMS_OP);
  endfunction

endpackage

// File: rtl/div_step.sv
// Combinational restoring-division slice retiring BITS_PER_CYCLE quotient bits, MSB first.
// No latency or flow control; the caller registers rem/quo between slices.
module div_step #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN-1:0] rem_v;
  logic [XLEN-1:0] quo_v;
  logic [XLEN:0]   shift_v;
  logic [XLEN+1:0] trial_v;

  // quo holds the not-yet-consumed dividend bits at the top and grows quotient bits at the bottom.
  always_comb begin
    rem_v   = rem_i;
    quo_v   = quo_i;
    shift_v = '0;
    trial_v = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      shift_v = {rem_v, quo_v[XLEN-1]};
      trial_v = {1'b0, shift_v} - {2'b00, div_i};
      if (trial_v[XLEN+1]) begin
        rem_v = shift_v[XLEN-1:0];
      end else begin
        rem_v = trial_v[XLEN-1:0];
      end
      quo_v = {quo_v[XLEN-2:0], ~trial_v[XLEN+1]};
    end
    rem_o = rem_v;
    quo_o = quo_v;
  end

endmodule

// File: rtl/div_unit.sv
// Iterative DIVU/DIVS/REMU/REMS; XLEN/BITS_PER_CYCLE+2 cycles, 1 cycle for b==0 or MIN/-1.
// Valid/ready both sides; result held in DONE until out_ready_i, flush_i/rst drop it.
module div_unit
  import alu_op_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  alu_op_t         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o
);

  localparam int ITER  = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] ITER_CNT = CNT_W'(ITER);
  localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [XLEN-1:0]  quo_q, rem_q, div_q, result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_quo_q, neg_rem_q, is_rem_q;

  logic            accept, sgn, rem_op, a_neg, b_neg, div_zero, overflow, special;
  logic [XLEN-1:0] a_abs, b_abs, special_res, fix_res, step_rem, step_quo;

  assign sgn      = op_is_signed(op_i);
  assign rem_op   = op_is_rem(op_i);
  assign a_neg    = sgn & a_i[XLEN-1];
  assign b_neg    = sgn & b_i[XLEN-1];
  assign a_abs    = a_neg ? (~a_i + 1'b1) : a_i;
  assign b_abs    = b_neg ? (~b_i + 1'b1) : b_i;
  assign div_zero = (b_i == '0);
  assign overflow = sgn & (a_i == MIN_INT) & (b_i == '1);
  assign special  = div_zero | overflow;

  // MIN/-1 quotient is MIN_INT, which is a_i itself.
  assign special_res = rem_op ? (div_zero ? a_i : '0) : (div_zero ? '1 : a_i);
  assign fix_res     = is_rem_q ? (neg_rem_q ? (~rem_q + 1'b1) : rem_q)
                                : (neg_quo_q ? (~quo_q + 1'b1) : quo_q);

  div_step #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_div_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (div_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d     = state_q;
    in_ready_o  = (state_q == IDLE) | ((state_q == DONE) & out_ready_i);
    out_valid_o = (state_q == DONE);
    result_o    = result_q;
    // Flush kills an accept in the same cycle while in_ready_o stays asserted.
    accept      = in_valid_i & in_ready_o & ~flush_i;
    case (state_q)
      IDLE: if (accept) state_d = special ? DONE : CALC;
      CALC: if (cnt_q == CNT_W'(1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (out_ready_i) state_d = accept ? (special ? DONE : CALC) : IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      quo_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        quo_q     <= a_abs;
        rem_q     <= '0;
        div_q     <= b_abs;
        cnt_q     <= ITER_CNT;
        neg_quo_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        is_rem_q  <= rem_op;
        if (special) result_q <= special_res;
      end else if (state_q == CALC) begin
        quo_q <= step_quo;
        rem_q <= step_rem;
        cnt_q <= cnt_q - 1'b1;
      end else if (state_q == FIX) begin
        result_q <= fix_res;
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboarded bench for div_unit at radix 2 (unit 0) and radix 4 (unit 1).
module tb_div_unit;
  import alu_op_pkg::*;

  localparam int L0 = 34;
  localparam int L1 = 18;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        flush_s     [2];
  logic        in_valid_s  [2];
  logic        in_ready_s  [2];
  alu_op_t     op_s        [2];
  logic [31:0] a_s         [2];
  logic [31:0] b_s         [2];
  logic        out_valid_s [2];
  logic        out_ready_s [2];
  logic [31:0] result_s    [2];

  div_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u_div_r1 (
    .clk(clk), .rst(rst), .flush_i(flush_s[0]), .in_valid_i(in_valid_s[0]),
    .in_ready_o(in_ready_s[0]), .op_i(op_s[0]), .a_i(a_s[0]), .b_i(b_s[0]),
    .out_valid_o(out_valid_s[0]), .out_ready_i(out_ready_s[0]), .result_o(result_s[0])
  );

  div_unit #(.XLEN(32), .BITS_PER_CYCLE(2)) u_div_r2 (
    .clk(clk), .rst(rst), .flush_i(flush_s[1]), .in_valid_i(in_valid_s[1]),
    .in_ready_o(in_ready_s[1]), .op_i(op_s[1]), .a_i(a_s[1]), .b_i(b_s[1]),
    .out_valid_o(out_valid_s[1]), .out_ready_i(out_ready_s[1]), .result_o(result_s[1])
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t  q0[$], q1[$];
  string n0[$], n1[$];
  bit    in_res [2] = '{0, 0};
  int    vstart [2] = '{0, 0};

  function automatic int qsize(input int u);
    return (u == 0) ? q0.size() : q1.size();
  endfunction

  task automatic mon(input int u);
    exp_t  e;
    string nm;
    if (rst) begin
      in_res[u] = 0;
      return;
    end
    if (!out_valid_s[u]) in_res[u] = 0;
    if (out_valid_s[u] && !in_res[u]) begin
      in_res[u] = 1;
      vstart[u] = cyc;
    end
    if (out_valid_s[u] && out_ready_s[u]) begin
      if (qsize(u) == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_u%0d actual=0x%08h required=no_output", u, result_s[u]);
      end else begin
        if (u == 0) begin e = q0.pop_front(); nm = n0.pop_front(); end
        else        begin e = q1.pop_front(); nm = n1.pop_front(); end
        check({nm, "_res"}, result_s[u], e.res);
        check({nm, "_lat"}, 32'(vstart[u] - e.acc), 32'(e.lat));
      end
      in_res[u] = 0;
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic issue(input int u, input alu_op_t o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] er, input int lat, input string nm, input bit push,
                       output int acc);
    exp_t e;
    int   w;
    w   = 0;
    acc = -1;
    in_valid_s[u] = 1'b1;
    op_s[u] = o;
    a_s[u]  = av;
    b_s[u]  = bv;
    while (acc < 0 && w < 200) begin
      @(negedge clk);
      if (in_ready_s[u] && !flush_s[u] && !rst) begin
        acc = cyc;
        if (push) begin
          e.res = er;
          e.lat = lat;
          e.acc = acc;
          if (u == 0) begin q0.push_back(e); n0.push_back(nm); end
          else        begin q1.push_back(e); n1.push_back(nm); end
        end
      end
      w++;
    end
    if (acc < 0) begin
      checks++;
      failures++;
      $display("FAIL %s_accept actual=timeout required=accepted", nm);
    end
    @(posedge clk);
    #1;
    in_valid_s[u] = 1'b0;
  endtask

  task automatic drain(input int u);
    int w;
    w = 0;
    while (qsize(u) != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (qsize(u) != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_u%0d actual=%0d_pending required=0", u, qsize(u));
      if (u == 0) begin q0.delete(); n0.delete(); end
      else        begin q1.delete(); n1.delete(); end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_res(input alu_op_t o, input logic [31:0] a, input logic [31:0] b);
    bit s, r;
    s = (o == 5'b01110) || (o == 5'b10000);
    r = (o == 5'b01111) || (o == 5'b10000);
    if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? 32'd0 : 32'h8000_0000;
    if (s) return r ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return r ? (a % b) : (a / b);
  endfunction

  function automatic int ref_lat(input int u, input alu_op_t o, input logic [31:0] a, input logic [31:0] b);
    bit s;
    s = (o == 5'b01110) || (o == 5'b10000);
    if (b == 32'd0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return (u == 0) ? L0 : L1;
  endfunction

  // Watches unit 0 for n cycles and reports how many had out_valid_o high.
  task automatic count_valid(input int n, output int seen);
    seen = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (out_valid_s[0]) seen++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_a, acc_b, acc_c, seen, w;
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      flush_s[u] = 1'b0; in_valid_s[u] = 1'b0; op_s[u] = '0;
      a_s[u] = '0; b_s[u] = '0; out_ready_s[u] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready_s[0]), 32'd1);
    check("rst_out_valid", 32'(out_valid_s[0]), 32'd0);
    check("rst_result", result_s[0], 32'd0);
    check("rst_in_ready_r2", 32'(in_ready_s[1]), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    issue(0, DIVU_OP, 32'd100,        32'd7,          32'd14,         L0, "divu_100_7",   1, acc_a);
    issue(0, REMU_OP, 32'd100,        32'd7,          32'd2,          L0, "remu_100_7",   1, acc_a);
    issue(0, DIVS_OP, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  L0, "divs_m7_2",    1, acc_a);
    issue(0, REMS_OP, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  L0, "rems_m7_2",    1, acc_a);
    issue(0, DIVS_OP, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  L0, "divs_7_m2",    1, acc_a);
    issue(0, REMS_OP, 32'd7,          32'hFFFF_FFFE,  32'd1,          L0, "rems_7_m2",    1, acc_a);
    issue(0, DIVU_OP, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  1,  "divu_by0",     1, acc_a);
    issue(0, REMU_OP, 32'h0000_1234,  32'd0,          32'h0000_1234,  1,  "remu_by0",     1, acc_a);
    issue(0, DIVS_OP, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  "divs_ovf",     1, acc_a);
    issue(0, REMS_OP, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  "rems_ovf",     1, acc_a);
    issue(0, REMS_OP, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1,  "rems_by0",     1, acc_a);
    issue(0, 5'b00011, 32'd100,       32'd7,          32'd14,         L0, "badop_as_divu",1, acc_a);
    issue(0, DIVU_OP, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  L0, "divu_max_1",   1, acc_a);
    issue(0, DIVS_OP, 32'h8000_0000,  32'd2,          32'hC000_0000,  L0, "divs_min_2",   1, acc_a);
    drain(0);

    // Back-to-back acceptance from DONE with no idle cycle.
    issue(0, DIVU_OP, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1,  "b2b_a", 1, acc_a);
    issue(0, DIVU_OP, 32'd100,       32'd7, 32'd14,        L0, "b2b_b", 1, acc_b);
    issue(0, REMU_OP, 32'd100,       32'd7, 32'd2,         L0, "b2b_c", 1, acc_c);
    check("b2b_gap_special", 32'(acc_b - acc_a), 32'd1);
    check("b2b_gap_calc", 32'(acc_c - acc_b), 32'(L0));
    drain(0);

    // Consumer stall: result must hold and no new op may be taken.
    out_ready_s[0] = 1'b0;
    issue(0, DIVS_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, L0, "stall", 1, acc_a);
    w = 0;
    while (!out_valid_s[0] && w < 100) begin
      @(negedge clk);
      w++;
    end
    for (int k = 0; k < 5; k++) begin
      check("stall_res", result_s[0], 32'hFFFF_FFFD);
      check("stall_in_ready", 32'(in_ready_s[0]), 32'd0);
      check("stall_out_valid", 32'(out_valid_s[0]), 32'd1);
      if (k < 4) @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready_s[0] = 1'b1;
    drain(0);

    // Flush at CALC iteration 10.
    issue(0, DIVU_OP, 32'd100, 32'd7, 32'd14, L0, "flushed", 0, acc_a);
    repeat (9) @(posedge clk);
    #1 flush_s[0] = 1'b1;
    @(posedge clk);
    #1 flush_s[0] = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid_s[0]), 32'd0);
    check("flush_in_ready", 32'(in_ready_s[0]), 32'd1);
    count_valid(40, seen);
    check("flush_no_result", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    issue(0, REMU_OP, 32'd100, 32'd7, 32'd2, L0, "after_flush", 1, acc_a);
    drain(0);

    // Flush and accept in the same cycle: nothing latched.
    in_valid_s[0] = 1'b1; op_s[0] = DIVU_OP; a_s[0] = 32'd5; b_s[0] = 32'd0; flush_s[0] = 1'b1;
    @(negedge clk);
    check("flush_acc_in_ready", 32'(in_ready_s[0]), 32'd1);
    @(posedge clk);
    #1 flush_s[0] = 1'b0; in_valid_s[0] = 1'b0;
    @(negedge clk);
    check("flush_acc_out_valid", 32'(out_valid_s[0]), 32'd0);
    check("flush_acc_in_ready2", 32'(in_ready_s[0]), 32'd1);
    @(posedge clk);
    #1;

    // Reset at CALC iteration 10.
    issue(0, DIVU_OP, 32'd100, 32'd7, 32'd14, L0, "reset_kill", 0, acc_a);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", 32'(out_valid_s[0]), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready_s[0]), 32'd1);
    check("rst_mid_result", result_s[0], 32'd0);
    count_valid(40, seen);
    check("rst_no_result", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    issue(0, DIVS_OP, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, L0, "after_rst", 1, acc_a);
    drain(0);

    // Radix-4 unit.
    issue(1, DIVU_OP, 32'hFFFF_FFFF, 32'd3,  32'h5555_5555, L1, "r2_divu_max_3", 1, acc_a);
    issue(1, REMU_OP, 32'd100,       32'd7,  32'd2,         L1, "r2_remu_100_7", 1, acc_a);
    issue(1, REMS_OP, 32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFF, L1, "r2_rems_m7_2",  1, acc_a);
    issue(1, DIVS_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "r2_divs_ovf", 1, acc_a);
    drain(1);

    for (int u = 0; u < 2; u++) begin
      for (int n = 0; n < 300; n++) begin
        alu_op_t     o;
        logic [31:0] av, bv;
        case ($urandom_range(0, 4))
          0:       o = DIVU_OP;
          1:       o = DIVS_OP;
          2:       o = REMU_OP;
          3:       o = REMS_OP;
          default: o = 5'b00001;
        endcase
        av = $urandom;
        bv = $urandom;
        case ($urandom_range(0, 7))
          0:       bv = 32'd0;
          1:       bv = 32'hFFFF_FFFF;
          2:       bv = 32'($urandom_range(1, 15));
          3:       bv = bv >> $urandom_range(1, 31);
          default: ;
        endcase
        if ($urandom_range(0, 7) == 0) av = 32'h8000_0000;
        issue(u, o, av, bv, ref_res(o, av, bv), ref_lat(u, o, av, bv),
              $sformatf("rnd_u%0d_%0d", u, n), 1, acc_a);
      end
      drain(u);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
